// File: rtl/mem_access.sv
// mem_access: memory-access stage of the mriscv pipeline.
//
// The stage accepts one operation from execute while idle. Non-memory
// results go straight to writeback. A load or store with a bad width code
// or a misaligned address raises mem_fault and touches nothing. Any other
// load or store is issued on the data-memory port. Until that access is
// finished, stall stays high and in_valid is ignored.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   in_valid          execute output valid
//   is_load/is_store  operation class (load wins if both are set)
//   func3             RV32I width code
//   addr              effective address
//   alu_result        value forwarded for non-memory ops
//   store_data        rs2 value for stores
//   dest_i            destination register
//   stall             stage busy (combinational from state)
//   mem_req/we/addr/wdata/wstrb   request to data memory, held until mem_ready
//   mem_ready         memory accepts the request this cycle
//   mem_rvalid/rdata  load response (only looked at while waiting for it)
//   wb_en/dest/data   register-file writeback; wb_en is a one-cycle pulse
//   mem_fault         one-cycle pulse for an illegal or misaligned access
//   dbg_state         current FSM state (0 idle, 1 request, 2 wait data)
//
// Handshake: a request is transferred on the rising edge where mem_req and
// mem_ready are both high. Until that edge, mem_req, mem_we, mem_addr,
// mem_wdata and mem_wstrb do not change. A load response is taken on the
// first rising edge in the wait state where mem_rvalid is high.
module mem_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  dest_i,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_en,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        mem_fault,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        ld_q, ld_d;         // accepted op is a load
   logic [2:0]  f3_q, f3_d;         // width code, needed again for extension
   logic [1:0]  off_q, off_d;       // byte offset within the word
   logic [4:0]  dest_q, dest_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        wb_en_q, wb_en_d;
   logic [4:0]  wb_dest_q, wb_dest_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        mem_fault_q, mem_fault_d;

   // Decode of the operation presented on the inputs.
   logic        illegal;
   logic        misaligned;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_wstrb;

   always_comb begin
      illegal = 1'b0;
      if (is_load) begin
         case (func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
            default:                                illegal = 1'b1;
         endcase
      end else begin
         case (func3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            default:                illegal = 1'b1;
         endcase
      end
      // The width follows from func3[1:0]. Codes with [1:0]=11 are already illegal.
      case (func3[1:0])
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = (addr[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
      // Store data is replicated across all lanes. The strobe selects the lanes to write.
      case (func3[1:0])
         2'b00: begin
            lane_wdata = {4{store_data[7:0]}};
            lane_wstrb = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            lane_wdata = {2{store_data[15:0]}};
            lane_wstrb = 4'b0011 << addr[1:0];
         end
         default: begin
            lane_wdata = store_data;
            lane_wstrb = 4'b1111;
         end
      endcase
   end

   // Load lane select and sign/zero extension (f3_q[2] set = unsigned).
   logic [31:0] shifted;
   logic [31:0] load_val;

   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (f3_q[1:0])
         2'b00:   load_val = {{24{shifted[7]  & ~f3_q[2]}}, shifted[7:0]};
         2'b01:   load_val = {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      ld_d        = ld_q;
      f3_d        = f3_q;
      off_d       = off_q;
      dest_d      = dest_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      wb_en_d     = 1'b0;
      wb_dest_d   = wb_dest_q;
      wb_data_d   = wb_data_q;
      mem_fault_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (!is_load && !is_store) begin
                  wb_en_d   = (dest_i != 5'd0);
                  wb_dest_d = dest_i;
                  wb_data_d = alu_result;
               end else if (illegal || misaligned) begin
                  mem_fault_d = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  ld_d        = is_load;
                  f3_d        = func3;
                  off_d       = addr[1:0];
                  dest_d      = dest_i;
                  mem_req_d   = 1'b1;
                  mem_we_d    = !is_load;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = lane_wdata;
                  mem_wstrb_d = is_load ? 4'b0000 : lane_wstrb;
               end
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               state_d     = ld_q ? ST_WAIT : ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               wb_en_d   = (dest_q != 5'd0);
               wb_dest_d = dest_q;
               wb_data_d = load_val;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ld_q        <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         dest_q      <= 5'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         mem_wstrb_q <= 4'd0;
         wb_en_q     <= 1'b0;
         wb_dest_q   <= 5'd0;
         wb_data_q   <= 32'd0;
         mem_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_q        <= ld_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         dest_q      <= dest_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         wb_en_q     <= wb_en_d;
         wb_dest_q   <= wb_dest_d;
         wb_data_q   <= wb_data_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   assign stall     = (state_q != ST_IDLE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign wb_en     = wb_en_q;
   assign wb_dest   = wb_dest_q;
   assign wb_data   = wb_data_q;
   assign mem_fault = mem_fault_q;
   assign dbg_state = state_q;

endmodule
